// File: rtl/tone_order_ctrl_if.sv
// Tone-ordering bus: bit-load table read port, fast and interleaved FWFT FIFO
// pop ports, and the valid/ready constellation-input output stream.
interface tone_order_ctrl_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNUMW = 8,
    parameter int unsigned TBLAW = 8,
    parameter int unsigned MAXB  = 15
);
    logic             tbl_rd_o;
    logic [TBLAW-1:0] tbl_addr_o;
    logic [3:0]       bitload_i;
    logic [CNUMW-1:0] carrier_i;

    logic             fast_empty_i;
    logic [DW-1:0]    fast_data_i;
    logic             fast_re_o;

    logic             inter_empty_i;
    logic [DW-1:0]    inter_data_i;
    logic             inter_re_o;

    logic             valid_o;
    logic             ready_i;
    logic [MAXB-1:0]  cin_o;
    logic [3:0]       bit_load_o;
    logic [CNUMW-1:0] carrier_num_o;

    modport master (
        output tbl_rd_o, tbl_addr_o, fast_re_o, inter_re_o,
        output valid_o, cin_o, bit_load_o, carrier_num_o,
        input  bitload_i, carrier_i, fast_empty_i, fast_data_i,
        input  inter_empty_i, inter_data_i, ready_i
    );

    modport slave (
        input  tbl_rd_o, tbl_addr_o, fast_re_o, inter_re_o,
        input  valid_o, cin_o, bit_load_o, carrier_num_o,
        output bitload_i, carrier_i, fast_empty_i, fast_data_i,
        output inter_empty_i, inter_data_i, ready_i
    );
endinterface

// File: rtl/tone_order_ctrl.sv
// DMT tone-ordering controller: walks the bit-load table for one symbol,
// pulls bytes from the fast then interleaved FIFO into a bit accumulator and
// emits one b-bit constellation input per loaded tone.
module tone_order_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNUMW = 8,
    parameter int unsigned TBLAW = 8,
    parameter int unsigned MAXB  = 15,
    parameter int unsigned SRW   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [TBLAW:0]      used_carrier_i,
    input  logic [7:0]          fast_bytes_i,
    output logic                busy_o,
    output logic                symbol_done_o,
    output logic                err_o,
    tone_order_ctrl_if.master   bus
);

    typedef enum logic [2:0] {StIdle, StRd, StWait, StFill, StEmit, StDone} state_e;

    state_e           state_q, state_d;
    logic [TBLAW:0]   used_q, used_d;
    logic [7:0]       fb_q, fb_d;
    logic [TBLAW:0]   tone_q, tone_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [SRW-1:0]   acc_q, acc_d;
    logic [4:0]       bcnt_q, bcnt_d;
    logic [3:0]       b_q, b_d;
    logic [CNUMW-1:0] carrier_q, carrier_d;
    logic [MAXB-1:0]  cin_q, cin_d;
    logic             err_q, err_d;

    logic             fast_re, inter_re;
    logic [TBLAW:0]   tone_inc;
    logic             last_tone;
    logic             use_fast;
    logic [MAXB-1:0]  cin_sel;

    assign tone_inc  = tone_q + 1'b1;
    assign last_tone = (tone_inc == used_q);
    // Fast path owns the first fast_bytes bytes of the symbol.
    assign use_fast  = (fcnt_q < fb_q);

    // Low b accumulator bits, upper bits forced to zero.
    always_comb begin
        cin_sel = '0;
        for (int i = 0; i < int'(MAXB); i++) begin
            if (i < int'(b_q)) cin_sel[i] = acc_q[i];
        end
    end

    // Next-state and datapath update for the symbol walk.
    always_comb begin
        state_d   = state_q;
        used_d    = used_q;
        fb_d      = fb_q;
        tone_d    = tone_q;
        fcnt_d    = fcnt_q;
        acc_d     = acc_q;
        bcnt_d    = bcnt_q;
        b_d       = b_q;
        carrier_d = carrier_q;
        cin_d     = cin_q;
        err_d     = err_q;
        fast_re   = 1'b0;
        inter_re  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    used_d  = used_carrier_i;
                    fb_d    = fast_bytes_i;
                    tone_d  = '0;
                    fcnt_d  = '0;
                    acc_d   = '0;
                    bcnt_d  = '0;
                    state_d = (used_carrier_i == '0) ? StDone : StRd;
                end
            end
            StRd: state_d = StWait;
            StWait: begin
                b_d       = bus.bitload_i;
                carrier_d = bus.carrier_i;
                if (bus.bitload_i < 4'd2) begin
                    // b=1 is not a legal constellation size: flag and skip.
                    if (bus.bitload_i == 4'd1) err_d = 1'b1;
                    tone_d  = tone_inc;
                    state_d = last_tone ? StDone : StRd;
                end else begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (bcnt_q >= {1'b0, b_q}) begin
                    cin_d   = cin_sel;
                    acc_d   = acc_q >> b_q;
                    bcnt_d  = bcnt_q - {1'b0, b_q};
                    state_d = StEmit;
                end else if (use_fast) begin
                    // No fallback to the other FIFO: stall until data arrives.
                    if (!bus.fast_empty_i) begin
                        fast_re = 1'b1;
                        acc_d   = acc_q | (SRW'(bus.fast_data_i) << bcnt_q);
                        bcnt_d  = bcnt_q + 5'd8;
                        if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
                    end
                end else if (!bus.inter_empty_i) begin
                    inter_re = 1'b1;
                    acc_d    = acc_q | (SRW'(bus.inter_data_i) << bcnt_q);
                    bcnt_d   = bcnt_q + 5'd8;
                end
            end
            StEmit: begin
                if (bus.ready_i) begin
                    tone_d  = tone_inc;
                    state_d = last_tone ? StDone : StRd;
                end
            end
            StDone: begin
                // Leftover bits mean the byte budget did not match the table.
                if (bcnt_q != '0) err_d = 1'b1;
                acc_d   = '0;
                bcnt_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            used_q    <= '0;
            fb_q      <= '0;
            tone_q    <= '0;
            fcnt_q    <= '0;
            acc_q     <= '0;
            bcnt_q    <= '0;
            b_q       <= '0;
            carrier_q <= '0;
            cin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            used_q    <= used_d;
            fb_q      <= fb_d;
            tone_q    <= tone_d;
            fcnt_q    <= fcnt_d;
            acc_q     <= acc_d;
            bcnt_q    <= bcnt_d;
            b_q       <= b_d;
            carrier_q <= carrier_d;
            cin_q     <= cin_d;
            err_q     <= err_d;
        end
    end

    assign bus.tbl_rd_o      = (state_q == StRd);
    assign bus.tbl_addr_o    = tone_q[TBLAW-1:0];
    assign bus.fast_re_o     = fast_re;
    assign bus.inter_re_o    = inter_re;
    assign bus.valid_o       = (state_q == StEmit);
    assign bus.cin_o         = cin_q;
    assign bus.bit_load_o    = b_q;
    assign bus.carrier_num_o = carrier_q;
    assign busy_o            = (state_q != StIdle);
    assign symbol_done_o     = (state_q == StDone);
    assign err_o             = err_q;

endmodule

// File: tb/tb_tone_order_ctrl.sv
// Bench for tone_order_ctrl: behavioural table/FIFO models, a bit-stream
// reference model, directed corner cases and randomized symbols.
module tb_tone_order_ctrl;
    localparam int DW = 8, CNUMW = 8, TBLAW = 8, MAXB = 15, SRW = 24;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [TBLAW:0]   used = '0;
    logic [7:0]       fbytes = '0;
    logic             busy, done, err;

    always #5 clk = ~clk;

    tone_order_ctrl_if #(.DW(DW), .CNUMW(CNUMW), .TBLAW(TBLAW), .MAXB(MAXB)) bus ();

    tone_order_ctrl #(.DW(DW), .CNUMW(CNUMW), .TBLAW(TBLAW), .MAXB(MAXB), .SRW(SRW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start),
        .used_carrier_i (used),
        .fast_bytes_i   (fbytes),
        .busy_o         (busy),
        .symbol_done_o  (done),
        .err_o          (err),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0]       tbl_b [256];
    logic [CNUMW-1:0] tbl_c [256];
    logic [7:0]       fast_mem [2048];
    logic [7:0]       inter_mem [2048];
    int fast_wr = 0, fast_rd = 0, inter_wr = 0, inter_rd = 0;
    int rec_cin[$], rec_bl[$], rec_cn[$];
    int done_cnt = 0, viol = 0, stab_viol = 0;
    int rmode = 0;
    logic err_exp = 1'b0;

    logic             hold_v = 1'b0;
    logic [MAXB-1:0]  hold_cin;
    logic [3:0]       hold_bl;
    logic [CNUMW-1:0] hold_cn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fast(input logic [7:0] v);
        fast_mem[fast_wr] = v;
        fast_wr++;
    endtask

    task automatic push_inter(input logic [7:0] v);
        inter_mem[inter_wr] = v;
        inter_wr++;
    endtask

    // Table, FIFOs and output-stream monitor.
    always @(posedge clk) begin
        if (bus.tbl_rd_o) begin
            bus.bitload_i <= tbl_b[bus.tbl_addr_o];
            bus.carrier_i <= tbl_c[bus.tbl_addr_o];
        end
        if (bus.fast_re_o && bus.inter_re_o) viol++;
        if (bus.fast_re_o) begin
            if (bus.fast_empty_i !== 1'b0) viol++;
            else fast_rd++;
        end
        if (bus.inter_re_o) begin
            if (bus.inter_empty_i !== 1'b0) viol++;
            else inter_rd++;
        end
        bus.fast_empty_i  <= (fast_rd >= fast_wr);
        bus.fast_data_i   <= fast_mem[fast_rd];
        bus.inter_empty_i <= (inter_rd >= inter_wr);
        bus.inter_data_i  <= inter_mem[inter_rd];
        if (bus.valid_o && bus.ready_i && !reset) begin
            rec_cin.push_back(int'(bus.cin_o));
            rec_bl.push_back(int'(bus.bit_load_o));
            rec_cn.push_back(int'(bus.carrier_num_o));
        end
        if (done) done_cnt++;
        if (hold_v && !reset) begin
            if (bus.valid_o !== 1'b1 || bus.cin_o !== hold_cin ||
                bus.bit_load_o !== hold_bl || bus.carrier_num_o !== hold_cn) stab_viol++;
        end
        hold_v   = bus.valid_o && !bus.ready_i && !reset;
        hold_cin = bus.cin_o;
        hold_bl  = bus.bit_load_o;
        hold_cn  = bus.carrier_num_o;
    end

    // Downstream ready: 0 always high, 1 random, 2 held low.
    always @(negedge clk) begin
        case (rmode)
            0:       bus.ready_i = 1'b1;
            1:       bus.ready_i = 1'($urandom_range(0, 1));
            default: bus.ready_i = 1'b0;
        endcase
    end

    // Bit p of the symbol's byte stream: fast bytes first, then interleaved.
    function automatic logic getbit(input int p, input int fb, input int fbase, input int ibase);
        int idx;
        logic [7:0] by;
        idx = p / 8;
        if (idx < fb) by = fast_mem[fbase + idx];
        else          by = inter_mem[ibase + idx - fb];
        return by[p % 8];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        err_exp = 1'b0;
    endtask

    task automatic wait_done(input int dbase);
        for (int c = 0; c < 3000 && done_cnt == dbase; c++) @(negedge clk);
    endtask

    // Run one symbol from table entries 0..n_used-1 and compare with the model.
    task automatic run_symbol(input string tag, input int n_used, input int fb);
        int pos, nbytes, fpop_exp, rbase, dbase, fbase, ibase, v;
        logic e;
        int q_cin[$], q_bl[$], q_cn[$];
        fbase = fast_rd; ibase = inter_rd;
        rbase = rec_cin.size(); dbase = done_cnt;
        pos = 0; e = 1'b0;
        for (int t = 0; t < n_used; t++) begin
            if (tbl_b[t] == 4'd1) e = 1'b1;
            else if (tbl_b[t] >= 4'd2) begin
                v = 0;
                for (int k = 0; k < int'(tbl_b[t]); k++)
                    v |= int'(getbit(pos + k, fb, fbase, ibase)) << k;
                q_cin.push_back(v);
                q_bl.push_back(int'(tbl_b[t]));
                q_cn.push_back(int'(tbl_c[t]));
                pos += int'(tbl_b[t]);
            end
        end
        nbytes   = (pos + 7) / 8;
        fpop_exp = (nbytes < fb) ? nbytes : fb;
        if (nbytes * 8 != pos) e = 1'b1;
        err_exp |= e;

        @(negedge clk);
        start  = 1'b1;
        used   = n_used[TBLAW:0];
        fbytes = fb[7:0];
        @(negedge clk);
        start = 1'b0;
        wait_done(dbase);
        check({tag, "_done"}, done_cnt - dbase, 1);
        check({tag, "_nout"}, rec_cin.size() - rbase, q_cin.size());
        for (int i = 0; i < q_cin.size(); i++) begin
            if (rbase + i < rec_cin.size()) begin
                check({tag, "_cin"}, rec_cin[rbase + i], q_cin[i]);
                check({tag, "_bl"},  rec_bl[rbase + i],  q_bl[i]);
                check({tag, "_cn"},  rec_cn[rbase + i],  q_cn[i]);
            end
        end
        check({tag, "_err"},    err, err_exp);
        check({tag, "_fpops"},  fast_rd - fbase, fpop_exp);
        check({tag, "_ipops"},  inter_rd - ibase, nbytes - fpop_exp);
        check({tag, "_idle"},   busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_tblrd"}, bus.tbl_rd_o, 0);
        check({tag, "_addr"},  bus.tbl_addr_o, 0);
        check({tag, "_re"},    {bus.fast_re_o, bus.inter_re_o}, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_cin"},   bus.cin_o, 0);
        check({tag, "_bl"},    bus.bit_load_o, 0);
        check({tag, "_cn"},    bus.carrier_num_o, 0);
    endtask

    initial begin
        int rbase, dbase, fbase, ibase, n, fb;

        // Reset state.
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Interleaved FIFO empty during FILL: stall without pops, then resume.
        tbl_b[0] = 4'd15; tbl_c[0] = 8'd9;
        push_fast(8'h12);
        rbase = rec_cin.size(); dbase = done_cnt; ibase = inter_rd; fbase = fast_rd;
        @(negedge clk); start = 1'b1; used = 9'd1; fbytes = 8'd1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_ire", bus.inter_re_o, 0);
            check("stall_valid", bus.valid_o, 0);
            @(negedge clk);
        end
        check("stall_busy", busy, 1);
        check("stall_ipops", inter_rd - ibase, 0);
        check("stall_fpops", fast_rd - fbase, 1);
        push_inter(8'h34);
        wait_done(dbase);
        check("stall_nout", rec_cin.size() - rbase, 1);
        if (rec_cin.size() > rbase) begin
            check("stall_cin", rec_cin[rbase], 32'h3412);
            check("stall_cn", rec_cn[rbase], 9);
        end
        check("stall_err", err, 1);

        // Reset asserted while stalled in FILL.
        do_reset();
        push_fast(8'h56);
        @(negedge clk); start = 1'b1; used = 9'd1; fbytes = 8'd1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_busy", busy, 1);
        reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        fbase = fast_rd; ibase = inter_rd;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_pops", (fast_rd - fbase) + (inter_rd - ibase), 0);

        // Single 2-bit tone: 0xA6 -> 0x2, six residual bits flag an error.
        do_reset();
        tbl_b[0] = 4'd2; tbl_c[0] = 8'd5;
        push_fast(8'hA6);
        rbase = rec_cin.size();
        run_symbol("one2b", 1, 1);
        if (rec_cin.size() > rbase) check("one2b_lit", rec_cin[rbase], 32'h2);
        check("one2b_errlit", err, 1);

        // Two 4-bit tones from one fast byte, no residual.
        do_reset();
        tbl_b[0] = 4'd4; tbl_c[0] = 8'd1;
        tbl_b[1] = 4'd4; tbl_c[1] = 8'd2;
        push_fast(8'h3C);
        rbase = rec_cin.size();
        run_symbol("two4b", 2, 1);
        if (rec_cin.size() > rbase + 1) begin
            check("two4b_lit0", rec_cin[rbase], 32'hC);
            check("two4b_lit1", rec_cin[rbase + 1], 32'h3);
        end

        // 15-bit tone spanning fast then interleaved FIFO.
        do_reset();
        tbl_b[0] = 4'd15; tbl_c[0] = 8'd7;
        push_fast(8'hFF); push_inter(8'h7F); push_inter(8'h00);
        rbase = rec_cin.size();
        run_symbol("max15", 1, 1);
        if (rec_cin.size() > rbase) check("max15_lit", rec_cin[rbase], 32'h7FFF);

        // Ready held low for 10 cycles in EMIT.
        do_reset();
        tbl_b[0] = 4'd8; tbl_c[0] = 8'd3;
        push_fast(8'h5A);
        rmode = 2;
        rbase = rec_cin.size(); dbase = done_cnt;
        @(negedge clk); start = 1'b1; used = 9'd1; fbytes = 8'd1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50 && bus.valid_o !== 1'b1; c++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", bus.valid_o, 1);
            check("hold_cin", bus.cin_o, 32'h5A);
            check("hold_bl", bus.bit_load_o, 8);
            check("hold_cn", bus.carrier_num_o, 3);
            @(negedge clk);
        end
        check("hold_noxfer", rec_cin.size() - rbase, 0);
        rmode = 0;
        wait_done(dbase);
        check("hold_nout", rec_cin.size() - rbase, 1);
        if (rec_cin.size() > rbase) check("hold_xcin", rec_cin[rbase], 32'h5A);
        check("hold_err", err, 0);

        // b=0 and b=1 entries between valid tones.
        do_reset();
        tbl_b[0] = 4'd4; tbl_c[0] = 8'd1;
        tbl_b[1] = 4'd0; tbl_c[1] = 8'd2;
        tbl_b[2] = 4'd1; tbl_c[2] = 8'd3;
        tbl_b[3] = 4'd4; tbl_c[3] = 8'd4;
        push_fast(8'h3C);
        rbase = rec_cin.size();
        run_symbol("skip", 4, 1);
        if (rec_cn.size() > rbase + 1) check("skip_cn1", rec_cn[rbase + 1], 4);
        check("skip_errlit", err, 1);

        // Empty symbol goes straight to DONE.
        do_reset();
        run_symbol("empty", 0, 0);

        // Randomized symbols with random back-pressure.
        rmode = 1;
        for (int s = 0; s < 30; s++) begin
            if (s % 3 == 0) do_reset();
            n  = $urandom_range(0, 12);
            fb = $urandom_range(0, 6);
            for (int t = 0; t < n; t++) begin
                tbl_b[t] = 4'($urandom_range(0, 15));
                tbl_c[t] = 8'($urandom);
            end
            for (int j = 0; j < fb; j++) push_fast(8'($urandom));
            for (int j = 0; j < 24; j++) push_inter(8'($urandom));
            run_symbol("rand", n, fb);
        end
        rmode = 0;

        check("fifo_rules", viol, 0);
        check("emit_stable", stab_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
